mem_req_arbiter: RTL and testbench

Parametrised N-client arbiter that multiplexes cache-side memory ports onto the single main-memory interface (req / req_data / resp channels) exported by `riscv_top`. It generalises the current one-Memory151-per-port arrangement so several requesters (e.g. icache, dcache, a future DMA) share one memory port. Requests are granted round-robin. Write bursts are locked to their owner until the last data beat. Responses are routed back by a client ID carried in the upper memory-tag bits.

---
 rtl/mem_req_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mem_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and types for the N-client main-memory request arbiter.
// Default widths mirror the MEM_* constants of the single-port memory interface.
package mem_req_arbiter_pkg;

   localparam int unsigned MemAddrBits  = 28;
   localparam int unsigned MemDataBits  = 128;
   localparam int unsigned MemTagBits   = 5;
   localparam int unsigned MemDataBeats = 4;

   typedef enum logic {StIdle, StWdata} state_e;

   // Client-ID field width carved out of the top of the memory tag.
   function automatic int unsigned id_bits(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// The pointer itself is owned by the caller.
module rr_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 2,
   localparam int unsigned ID_BITS    = id_bits(NUM_CLIENTS)
) (
   input  logic [NUM_CLIENTS-1:0] req_i,
   input  logic [ID_BITS-1:0]     ptr_i,
   output logic [NUM_CLIENTS-1:0] gnt_o,
   output logic [ID_BITS-1:0]     idx_o,
   output logic                   any_o
);

   always_comb begin
      logic                found;
      int unsigned         c;
      logic [ID_BITS-1:0]  cidx;
      found = 1'b0;
      idx_o = '0;
      gnt_o = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         c    = (32'(ptr_i) + k) % NUM_CLIENTS;
         cidx = c[ID_BITS-1:0];
         if (!found && req_i[cidx]) begin
            found = 1'b1;
            idx_o = cidx;
         end
      end
      gnt_o[idx_o] = found;
      any_o        = found;
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin N-client front end for the single main-memory port. Write bursts stay
// locked to their owner until the last beat; responses are routed by the tag's ID field.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_BITS   = MemAddrBits,
   parameter int unsigned DATA_BITS   = MemDataBits,
   parameter int unsigned TAG_BITS    = MemTagBits,
   parameter int unsigned DATA_BEATS  = MemDataBeats,
   localparam int unsigned ID_BITS    = id_bits(NUM_CLIENTS),
   localparam int unsigned CT_BITS    = TAG_BITS - ID_BITS,
   localparam int unsigned MASK_BITS  = DATA_BITS / 8,
   localparam int unsigned BEAT_BITS  = $clog2(DATA_BEATS + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CLIENTS-1:0]           cli_req_valid,
   output logic [NUM_CLIENTS-1:0]           cli_req_ready,
   input  logic [NUM_CLIENTS-1:0]           cli_req_rw,
   input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cli_req_addr,
   input  logic [NUM_CLIENTS*CT_BITS-1:0]   cli_req_tag,
   input  logic [NUM_CLIENTS-1:0]           cli_req_data_valid,
   output logic [NUM_CLIENTS-1:0]           cli_req_data_ready,
   input  logic [NUM_CLIENTS*DATA_BITS-1:0] cli_req_data_bits,
   input  logic [NUM_CLIENTS*MASK_BITS-1:0] cli_req_data_mask,
   output logic [NUM_CLIENTS-1:0]           cli_resp_valid,
   output logic [NUM_CLIENTS*CT_BITS-1:0]   cli_resp_tag,
   output logic [NUM_CLIENTS*DATA_BITS-1:0] cli_resp_data,
   output logic                             mem_req_valid,
   input  logic                             mem_req_ready,
   output logic                             mem_req_rw,
   output logic [ADDR_BITS-1:0]             mem_req_addr,
   output logic [TAG_BITS-1:0]              mem_req_tag,
   output logic                             mem_req_data_valid,
   input  logic                             mem_req_data_ready,
   output logic [DATA_BITS-1:0]             mem_req_data_bits,
   output logic [MASK_BITS-1:0]             mem_req_data_mask,
   input  logic                             mem_resp_valid,
   input  logic [TAG_BITS-1:0]              mem_resp_tag,
   input  logic [DATA_BITS-1:0]             mem_resp_data
);

   state_e               state_q, state_d;
   logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_BITS-1:0]   owner_q, owner_d;
   logic [BEAT_BITS-1:0] beat_q, beat_d;

   logic [NUM_CLIENTS-1:0] gnt;
   logic [ID_BITS-1:0]     winner;
   logic                   any_req;
   logic                   req_fire, data_fire;

   rr_arbiter #(
      .NUM_CLIENTS(NUM_CLIENTS)
   ) u_rr_arbiter (
      .req_i(cli_req_valid),
      .ptr_i(rr_ptr_q),
      .gnt_o(gnt),
      .idx_o(winner),
      .any_o(any_req)
   );

   function automatic logic [ID_BITS-1:0] next_id(input logic [ID_BITS-1:0] id);
      return (id == ID_BITS'(NUM_CLIENTS - 1)) ? '0 : id + 1'b1;
   endfunction

   always_comb begin
      mem_req_valid      = 1'b0;
      mem_req_data_valid = 1'b0;
      cli_req_ready      = '0;
      cli_req_data_ready = '0;
      req_fire           = 1'b0;
      data_fire          = 1'b0;
      mem_req_rw         = cli_req_rw[winner];
      mem_req_addr       = cli_req_addr[winner*ADDR_BITS +: ADDR_BITS];
      mem_req_tag        = {winner, cli_req_tag[winner*CT_BITS +: CT_BITS]};
      mem_req_data_bits  = cli_req_data_bits[owner_q*DATA_BITS +: DATA_BITS];
      mem_req_data_mask  = cli_req_data_mask[owner_q*MASK_BITS +: MASK_BITS];
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               mem_req_valid = any_req;
               cli_req_ready = gnt & {NUM_CLIENTS{mem_req_ready}};
               req_fire      = any_req & mem_req_ready;
            end
            StWdata: begin
               mem_req_data_valid          = cli_req_data_valid[owner_q];
               cli_req_data_ready[owner_q] = mem_req_data_ready;
               data_fire                   = cli_req_data_valid[owner_q] & mem_req_data_ready;
            end
            default: ;
         endcase
      end
   end

   // Response routing ignores arbiter state; IDs >= NUM_CLIENTS match no client.
   always_comb begin
      cli_resp_valid = '0;
      cli_resp_tag   = '0;
      cli_resp_data  = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         cli_resp_valid[i] = !reset && mem_resp_valid &&
                             (mem_resp_tag[TAG_BITS-1 -: ID_BITS] == ID_BITS'(i));
         cli_resp_tag[i*CT_BITS +: CT_BITS]       = mem_resp_tag[CT_BITS-1:0];
         cli_resp_data[i*DATA_BITS +: DATA_BITS]  = mem_resp_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      beat_d   = beat_q;
      if (req_fire) begin
         if (mem_req_rw) begin
            owner_d = winner;
            beat_d  = '0;
            state_d = StWdata;
         end else begin
            rr_ptr_d = next_id(winner);
         end
      end
      if (data_fire) begin
         if (beat_q == BEAT_BITS'(DATA_BEATS - 1)) begin
            beat_d   = '0;
            rr_ptr_d = next_id(owner_q);
            state_d  = StIdle;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         beat_q   <= beat_d;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomised scoreboard bench for mem_req_arbiter (2 clients, 5-bit tags, 4-beat writes).
module tb_mem_req_arbiter;

   localparam int N  = 2;
   localparam int AB = 16;
   localparam int DB = 32;
   localparam int TB = 5;
   localparam int BE = 4;
   localparam int CT = TB - 1;
   localparam int MB = DB / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    cli_req_valid, cli_req_ready, cli_req_rw;
   logic [N*AB-1:0] cli_req_addr;
   logic [N*CT-1:0] cli_req_tag;
   logic [N-1:0]    cli_req_data_valid, cli_req_data_ready;
   logic [N*DB-1:0] cli_req_data_bits;
   logic [N*MB-1:0] cli_req_data_mask;
   logic [N-1:0]    cli_resp_valid;
   logic [N*CT-1:0] cli_resp_tag;
   logic [N*DB-1:0] cli_resp_data;
   logic            mem_req_valid, mem_req_ready, mem_req_rw;
   logic [AB-1:0]   mem_req_addr;
   logic [TB-1:0]   mem_req_tag;
   logic            mem_req_data_valid, mem_req_data_ready;
   logic [DB-1:0]   mem_req_data_bits;
   logic [MB-1:0]   mem_req_data_mask;
   logic            mem_resp_valid;
   logic [TB-1:0]   mem_resp_tag;
   logic [DB-1:0]   mem_resp_data;

   mem_req_arbiter #(
      .NUM_CLIENTS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .DATA_BEATS(BE)
   ) dut (
      .clk(clk), .reset(reset),
      .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready), .cli_req_rw(cli_req_rw),
      .cli_req_addr(cli_req_addr), .cli_req_tag(cli_req_tag),
      .cli_req_data_valid(cli_req_data_valid), .cli_req_data_ready(cli_req_data_ready),
      .cli_req_data_bits(cli_req_data_bits), .cli_req_data_mask(cli_req_data_mask),
      .cli_resp_valid(cli_resp_valid), .cli_resp_tag(cli_resp_tag),
      .cli_resp_data(cli_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
      .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  cli;
      logic [63:0] pay;
      logic [7:0]  vec;
   } rec_t;

   rec_t req_q[$], data_q[$], resp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   // Reference model: protocol-level view of who may talk on the memory port.
   bit m_idle = 1'b1;
   int m_ptr = 0, m_owner = 0, m_beats = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp_rec(input string nm, input bit fire, input bit have, input rec_t e,
                          input logic [63:0] pay, input logic [7:0] vec);
      if (!have) check({nm, "_unexpected"}, 1, 0);
      else if (!fire) check({nm, "_missing"}, 0, 1);
      else begin
         check({nm, "_payload"}, pay, e.pay);
         check({nm, "_onehot"}, vec, e.vec);
      end
   endtask

   task automatic drive(input bit rst, input int mode);
      int w, bd, d;
      rec_t r;
      @(posedge clk);
      #1;
      reset = rst;
      for (int i = 0; i < N; i++) begin
         cli_req_valid[i]            = ($urandom % 5) < 3;
         cli_req_rw[i]               = ($urandom % 3) == 0;
         cli_req_addr[i*AB +: AB]    = AB'($urandom);
         cli_req_tag[i*CT +: CT]     = CT'($urandom);
         cli_req_data_valid[i]       = ($urandom % 4) != 0;
         cli_req_data_bits[i*DB +: DB] = $urandom;
         cli_req_data_mask[i*MB +: MB] = MB'($urandom);
      end
      mem_req_ready      = ($urandom % 4) != 0;
      mem_req_data_ready = ($urandom % 3) != 0;
      mem_resp_valid     = ($urandom % 3) == 0;
      mem_resp_tag       = TB'($urandom);
      mem_resp_data      = $urandom;
      if (mode == 1) begin
         cli_req_valid = '1;
         cli_req_rw    = '0;
         mem_req_ready = 1'b1;
      end else if (mode == 2) begin
         cli_req_valid       = 2'b11;
         cli_req_rw          = 2'b01;
         cli_req_addr[0 +: AB] = 16'h0100;
         cli_req_data_valid  = '1;
         mem_req_ready       = 1'b1;
         mem_req_data_ready  = 1'b1;
         mem_resp_valid      = 1'b1;
         mem_resp_tag        = 5'b1_0011;
      end else if (mode == 3) begin
         cli_req_valid      = '0;
         cli_req_data_valid = '0;
         mem_resp_valid     = 1'b0;
      end
      if (rst) begin
         m_idle = 1'b1; m_ptr = 0; m_owner = 0; m_beats = 0;
         return;
      end
      if (mem_resp_valid) begin
         w     = int'(mem_resp_tag[TB-1]);
         r.cyc = cyc; r.cli = 8'(w); r.vec = 8'(1 << w);
         r.pay = {28'd0, mem_resp_tag[CT-1:0], mem_resp_data};
         resp_q.push_back(r);
      end
      if (m_idle) begin
         // Winner = valid client with the smallest forward distance from the pointer.
         w = -1; bd = N;
         for (int c = 0; c < N; c++) begin
            d = (c - m_ptr + N) % N;
            if (cli_req_valid[c] && d < bd) begin w = c; bd = d; end
         end
         if (w >= 0 && mem_req_ready) begin
            r.cyc = cyc; r.cli = 8'(w); r.vec = 8'(1 << w);
            r.pay = {42'd0, cli_req_rw[w], cli_req_addr[w*AB +: AB], 1'(w),
                     cli_req_tag[w*CT +: CT]};
            req_q.push_back(r);
            if (cli_req_rw[w]) begin
               m_idle = 1'b0; m_owner = w; m_beats = 0;
            end else m_ptr = (w + 1) % N;
         end
      end else if (cli_req_data_valid[m_owner] && mem_req_data_ready) begin
         r.cyc = cyc; r.cli = 8'(m_owner); r.vec = 8'(1 << m_owner);
         r.pay = {28'd0, cli_req_data_mask[m_owner*MB +: MB], cli_req_data_bits[m_owner*DB +: DB]};
         data_q.push_back(r);
         m_beats++;
         if (m_beats == BE) begin
            m_idle = 1'b1; m_ptr = (m_owner + 1) % N;
         end
      end
   endtask

   always @(negedge clk) begin
      bit   fire, have;
      rec_t e;
      int   k;
      if (reset === 1'b1) begin
         check("reset_quiet", {mem_req_valid, mem_req_data_valid, cli_req_ready,
                               cli_req_data_ready, cli_resp_valid}, '0);
      end else if (reset === 1'b0) begin
         fire = mem_req_valid && mem_req_ready;
         have = req_q.size() > 0 && req_q[0].cyc == cyc;
         if (fire || have) begin
            e = have ? req_q.pop_front() : '0;
            cmp_rec("req", fire, have, e, {42'd0, mem_req_rw, mem_req_addr, mem_req_tag},
                    8'(cli_req_ready));
         end
         fire = mem_req_data_valid && mem_req_data_ready;
         have = data_q.size() > 0 && data_q[0].cyc == cyc;
         if (fire || have) begin
            e = have ? data_q.pop_front() : '0;
            cmp_rec("data", fire, have, e, {28'd0, mem_req_data_mask, mem_req_data_bits},
                    8'(cli_req_data_ready));
         end
         fire = |cli_resp_valid;
         have = resp_q.size() > 0 && resp_q[0].cyc == cyc;
         if (fire || have) begin
            e = have ? resp_q.pop_front() : '0;
            k = int'(e.cli) % N;
            cmp_rec("resp", fire, have, e, {28'd0, cli_resp_tag[k*CT +: CT],
                    cli_resp_data[k*DB +: DB]}, 8'(cli_resp_valid));
         end
      end
   end

   initial begin
      bit did_rst;
      reset = 1'b1;
      cli_req_valid = '0; cli_req_rw = '0; cli_req_addr = '0; cli_req_tag = '0;
      cli_req_data_valid = '0; cli_req_data_bits = '0; cli_req_data_mask = '0;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
      repeat (3) drive(1'b1, 0);
      repeat (20) drive(1'b0, 1);
      for (int i = 0; i < 3000; i++) drive(($urandom % 200) == 0, 0);
      drive(1'b1, 3);
      did_rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (!did_rst && !m_idle && m_beats == 2) begin
            did_rst = 1'b1;
            drive(1'b1, 2);
         end else drive(1'b0, 2);
      end
      repeat (3) drive(1'b0, 3);
      @(negedge clk);
      #1;
      check("req_q_drained", 32'(req_q.size()), 0);
      check("data_q_drained", 32'(data_q.size()), 0);
      check("resp_q_drained", 32'(resp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
